// File: rtl/psram_wbuf_pkg.sv
// Shared types for the PSRAM byte-to-word write buffer.
// Entry layout, address widths and lane helpers.
package psram_wbuf_pkg;

    localparam int WADDR_W     = 21;
    localparam int BYTE_ADDR_W = 22;

    typedef struct packed {
        logic [WADDR_W-1:0] waddr;
        logic [15:0]        data;
        logic [1:0]         be;
    } wbuf_entry_t;

    function automatic logic [1:0] lane_mask(input logic lane);
        return lane ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with registered occupancy count.
// Push while full and pop while empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem[rptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage array, written at the tail.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

    // Pointers wrap naturally; count tracks net push/pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr    <= '0;
            rptr    <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/psram_write_buffer.sv
// Coalesces byte writes into masked 16-bit PSRAM word writes.
// Staging word feeds a FIFO whose head drives the controller.
module psram_write_buffer
    import psram_wbuf_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int IDLE_FLUSH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_req,
    input  logic [BYTE_ADDR_W-1:0] wr_addr,
    input  logic [7:0]             wr_data,
    output logic                   busy,
    input  logic                   flush,
    output logic                   drained,
    output logic                   overflow,
    output logic                   mem_req,
    output logic [WADDR_W-1:0]     mem_addr,
    output logic [15:0]            mem_wdata,
    output logic [1:0]             mem_be,
    input  logic                   mem_ack
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int IW = $clog2(IDLE_FLUSH + 1);
    localparam int EW = $bits(wbuf_entry_t);

    logic        stg_valid, stg_valid_nxt;
    wbuf_entry_t stg, stg_nxt, head;
    logic [IW-1:0] idle_cnt, idle_nxt;
    logic        flush_pend, flush_pend_nxt;
    logic        busy_q, drained_q, ovf_q;

    logic          f_full, f_empty, f_pop, stg_push;
    logic [EW-1:0] f_rdata;
    logic [CW-1:0] f_count, cnt_nxt;

    logic          acc, lane, same_word, new_word, timeout, served;
    logic [1:0]    mask;

    sync_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (stg_push),
        .wdata (stg),
        .pop   (f_pop),
        .rdata (f_rdata),
        .full  (f_full),
        .empty (f_empty),
        .count (f_count)
    );

    assign head = wbuf_entry_t'(f_rdata);

    // Staging, idle timer and flush latch next-state decisions.
    always_comb begin
        lane      = wr_addr[0];
        mask      = lane_mask(lane);
        acc       = wr_req && !busy_q;
        same_word = stg.waddr == wr_addr[BYTE_ADDR_W-1:1];
        new_word  = acc && stg_valid && (!same_word || ((stg.be & mask) != 2'b00));
        timeout   = idle_cnt >= IW'(IDLE_FLUSH - 1);
        stg_push  = new_word ||
                    (!acc && stg_valid && (flush_pend || timeout) && !f_full);
        served    = flush_pend &&
                    (new_word || (!acc && (!stg_valid || !f_full)));
        flush_pend_nxt = flush || (flush_pend && !served);
        f_pop     = mem_ack && !f_empty;
        cnt_nxt   = f_count + CW'(stg_push) - CW'(f_pop);

        stg_valid_nxt = stg_valid;
        stg_nxt       = stg;
        if (acc) begin
            if (!stg_valid || new_word) begin
                stg_valid_nxt = 1'b1;
                stg_nxt.waddr = wr_addr[BYTE_ADDR_W-1:1];
                stg_nxt.data  = '0;
                stg_nxt.be    = mask;
            end else begin
                stg_nxt.be = stg.be | mask;
            end
            if (lane) stg_nxt.data[15:8] = wr_data;
            else      stg_nxt.data[7:0]  = wr_data;
        end else if (stg_push) begin
            stg_valid_nxt = 1'b0;
            stg_nxt       = '0;
        end

        if (acc)                           idle_nxt = '0;
        else if (idle_cnt == IW'(IDLE_FLUSH)) idle_nxt = idle_cnt;
        else                               idle_nxt = idle_cnt + 1'b1;
    end

    // State and registered status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stg_valid  <= 1'b0;
            stg        <= '0;
            idle_cnt   <= '0;
            flush_pend <= 1'b0;
            busy_q     <= 1'b0;
            drained_q  <= 1'b1;
            ovf_q      <= 1'b0;
        end else begin
            stg_valid  <= stg_valid_nxt;
            stg        <= stg_nxt;
            idle_cnt   <= idle_nxt;
            flush_pend <= flush_pend_nxt;
            busy_q     <= (CW'(DEPTH) - cnt_nxt) < CW'(2);
            drained_q  <= !stg_valid_nxt && (cnt_nxt == '0) && !flush_pend_nxt;
            if (wr_req && busy_q) ovf_q <= 1'b1;
        end
    end

    assign busy      = busy_q;
    assign drained   = drained_q;
    assign overflow  = ovf_q;
    assign mem_req   = !f_empty;
    assign mem_addr  = f_empty ? '0 : head.waddr;
    assign mem_wdata = f_empty ? '0 : head.data;
    assign mem_be    = f_empty ? '0 : head.be;

endmodule

// File: tb/tb_psram_write_buffer.sv
// Directed bench for the PSRAM write coalescing buffer.
// Hand-computed expected words checked at the FIFO head.
module tb_psram_write_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_req;
    logic [21:0] wr_addr;
    logic [7:0]  wr_data;
    logic        busy;
    logic        flush;
    logic        drained;
    logic        overflow;
    logic        mem_req;
    logic [20:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [1:0]  mem_be;
    logic        mem_ack;

    int checks   = 0;
    int failures = 0;

    psram_write_buffer #(.DEPTH(16), .IDLE_FLUSH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .flush     (flush),
        .drained   (drained),
        .overflow  (overflow),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_ack   (mem_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_byte(input logic [21:0] a, input logic [7:0] d);
        wr_req  = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_req  = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic ack();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
    endtask

    task automatic wait_req(input string tag, output int cyc);
        cyc = 0;
        while (!mem_req && cyc < 50) begin
            tick();
            cyc++;
        end
        check({tag, "_req"}, 32'(mem_req), 32'd1);
    endtask

    task automatic expect_head(input string tag, input logic [20:0] a,
                               input logic [15:0] d, input logic [1:0] be);
        int cyc;
        wait_req(tag, cyc);
        check({tag, "_addr"}, 32'(mem_addr), 32'(a));
        check({tag, "_data"}, 32'(mem_wdata), 32'(d));
        check({tag, "_be"}, 32'(mem_be), 32'(be));
    endtask

    task automatic quiet(input string tag, input int n);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            seen = seen | mem_req;
        end
        check(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        int cyc;
        int acc_n;
        logic [7:0] lo;
        logic [7:0] hi;
        reset   = 1'b1;
        wr_req  = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        flush   = 1'b0;
        mem_ack = 1'b0;
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_drained", 32'(drained), 32'd1);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_data", 32'(mem_wdata), 32'd0);
        check("rst_be", 32'(mem_be), 32'd0);
        reset = 1'b0;
        tick();

        // Two lanes of one word merged, then flushed.
        put_byte(22'h004000, 8'hAA);
        put_byte(22'h004001, 8'hBB);
        pulse_flush();
        expect_head("merge", 21'h002000, 16'hBBAA, 2'b11);
        check("merge_notdrained", 32'(drained), 32'd0);
        ack();
        check("merge_req_lo", 32'(mem_req), 32'd0);
        check("merge_drained", 32'(drained), 32'd1);

        // Single upper-lane byte pushed by idle timeout.
        put_byte(22'h004003, 8'h5C);
        wait_req("idle", cyc);
        check("idle_lat", 32'(cyc), 32'd8);
        check("idle_addr", 32'(mem_addr), 32'h002001);
        check("idle_hi", 32'(mem_wdata[15:8]), 32'h5C);
        check("idle_be", 32'(mem_be), 32'b10);
        ack();

        // Same lane twice: two writes in order.
        put_byte(22'h000010, 8'h11);
        put_byte(22'h000010, 8'h22);
        pulse_flush();
        expect_head("rep0", 21'h000008, 16'h0011, 2'b01);
        ack();
        expect_head("rep1", 21'h000008, 16'h0022, 2'b01);
        ack();
        check("rep_drained", 32'(drained), 32'd1);

        // Count 3, then push and pop on the same edge.
        put_byte(22'h000200, 8'h01);
        put_byte(22'h000202, 8'h02);
        put_byte(22'h000204, 8'h03);
        put_byte(22'h000206, 8'h04);
        check("pp_head0", 32'(mem_addr), 32'h000100);
        wr_req  = 1'b1;
        wr_addr = 22'h000208;
        wr_data = 8'h05;
        mem_ack = 1'b1;
        tick();
        wr_req  = 1'b0;
        mem_ack = 1'b0;
        check("pp_head1", 32'(mem_addr), 32'h000101);
        check("pp_data1", 32'(mem_wdata), 32'h0002);
        ack();
        check("pp_head2", 32'(mem_addr), 32'h000102);
        ack();
        check("pp_head3", 32'(mem_addr), 32'h000103);
        check("pp_data3", 32'(mem_wdata), 32'h0004);
        ack();
        check("pp_count3", 32'(mem_req), 32'd0);
        expect_head("pp_tail", 21'h000104, 16'h0005, 2'b01);
        ack();

        // Fill with acks held low until back-pressure.
        acc_n = 0;
        for (int k = 0; k < 40; k++) begin
            if (busy) break;
            put_byte(22'h000100 + 22'(k), 8'(32'h40 + k));
            acc_n++;
        end
        check("fill_accepted", 32'(acc_n), 32'd31);
        check("fill_busy", 32'(busy), 32'd1);
        check("ovf_pre", 32'(overflow), 32'd0);
        put_byte(22'h003000, 8'hEE);
        check("ovf_set", 32'(overflow), 32'd1);
        pulse_flush();
        for (int j = 0; j < 15; j++) begin
            lo = 8'(32'h40 + 2 * j);
            hi = 8'(32'h41 + 2 * j);
            expect_head($sformatf("fill%0d", j), 21'h80 + 21'(j),
                        {hi, lo}, 2'b11);
            ack();
        end
        expect_head("fill15", 21'h00008F, 16'h005E, 2'b01);
        ack();
        check("fill_drained", 32'(drained), 32'd1);
        check("fill_busy_lo", 32'(busy), 32'd0);
        quiet("fill_no_extra", 12);

        // Reset while words are queued.
        put_byte(22'h000400, 8'h01);
        put_byte(22'h000402, 8'h02);
        check("mid_req", 32'(mem_req), 32'd1);
        reset = 1'b1;
        tick();
        check("mid_req_lo", 32'(mem_req), 32'd0);
        check("mid_drained", 32'(drained), 32'd1);
        check("mid_ovf", 32'(overflow), 32'd0);
        reset = 1'b0;
        quiet("mid_no_stale", 12);
        check("mid_drained2", 32'(drained), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
